// File: rtl/uart_ibus_bridge_pkg.sv
// Shared constants for the UART-to-ibus bridge: command bytes, parser and
// receiver state encodings, and a byte-join helper.
package uart_ibus_bridge_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h06;

  localparam logic [3:0] P_IDLE     = 4'd0;
  localparam logic [3:0] P_ADR_H    = 4'd1;
  localparam logic [3:0] P_ADR_L    = 4'd2;
  localparam logic [3:0] P_DAT_H    = 4'd3;
  localparam logic [3:0] P_DAT_L    = 4'd4;
  localparam logic [3:0] P_ISSUE    = 4'd5;
  localparam logic [3:0] P_WAIT_RD  = 4'd6;
  localparam logic [3:0] P_SEND_H   = 4'd7;
  localparam logic [3:0] P_SEND_L   = 4'd8;
  localparam logic [3:0] P_SEND_ACK = 4'd9;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  function automatic logic [15:0] join16(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_ibus_bridge_byte_rx.sv
// uart_byte_rx: 2-FF synchroniser, 8N1 bit timing and stop-bit check.
// Emits one-cycle valid_o with data_o, or ferr_o when the stop bit reads 0.
module uart_byte_rx
  import uart_ibus_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic          meta_q, sync_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  // Frame sequencing: start rechecked at half-bit, then every full bit is a mid-bit sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          state_d = RX_IDLE;
          if (sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/uart_ibus_bridge.sv
// UART command front-end driving the systolic4 ibus ('W' aH aL dH dL / 'R' aH aL).
// Define UART_IBUS_ACK_EN to send an 0x06 acknowledge byte after every write strobe.
module uart_ibus_bridge
  import uart_ibus_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LAT       = 1,
  parameter int TIMEOUT_CLKS = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        ren,
  output logic [15:0] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        wen,
  output logic [15:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int LW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_M1 = TW'(TIMEOUT_CLKS - 1);
  localparam logic [LW-1:0] LAT_M1 = LW'(RD_LAT - 1);

  logic [7:0] rx_data_s;
  logic       rx_valid_s, rx_ferr_s;

  uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx_i    (rx),
    .data_o  (rx_data_s),
    .valid_o (rx_valid_s),
    .ferr_o  (rx_ferr_s)
  );

  logic [3:0]    state_q, state_d;
  logic          is_rd_q, is_rd_d;
  logic [15:0]   adr_q, adr_d;
  logic [7:0]    dat_h_q, dat_h_d, reply_lo_q, reply_lo_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          ren_q, ren_d, wen_q, wen_d;
  logic [15:0]   radr_q, radr_d, wadr_q, wadr_d, wdata_q, wdata_d;
  logic          ferr_q, ferr_d, busy_q;
  logic          tx_start_s, tx_done_s;
  logic [7:0]    tx_byte_s;
  logic          tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;

  assign tx_done_s = tx_busy_q && (tx_cnt_q == BIT_M1) && (tx_bit_q == 4'd9);

  // Command parser; strobes are registered so they coincide with the ISSUE state.
  always_comb begin
    state_d    = state_q;
    is_rd_d    = is_rd_q;
    adr_d      = adr_q;
    dat_h_d    = dat_h_q;
    reply_lo_d = reply_lo_q;
    tmo_d      = tmo_q;
    lat_d      = lat_q;
    ren_d      = 1'b0;
    wen_d      = 1'b0;
    radr_d     = radr_q;
    wadr_d     = wadr_q;
    wdata_d    = wdata_q;
    ferr_d     = ferr_q | rx_ferr_s;
    tx_start_s = 1'b0;
    tx_byte_s  = 8'h00;
    case (state_q)
      P_IDLE: begin
        tmo_d = '0;
        if (rx_valid_s && (rx_data_s == CMD_WR || rx_data_s == CMD_RD)) begin
          is_rd_d = (rx_data_s == CMD_RD);
          state_d = P_ADR_H;
        end else begin
          state_d = P_IDLE;
        end
      end
      P_ADR_H, P_ADR_L, P_DAT_H, P_DAT_L: begin
        if (rx_ferr_s) begin
          state_d = P_IDLE;
          tmo_d   = '0;
        end else if (rx_valid_s) begin
          tmo_d = '0;
          case (state_q)
            P_ADR_H: begin
              adr_d[15:8] = rx_data_s;
              state_d     = P_ADR_L;
            end
            P_ADR_L: begin
              adr_d[7:0] = rx_data_s;
              if (is_rd_q) begin
                ren_d   = 1'b1;
                radr_d  = join16(adr_q[15:8], rx_data_s);
                state_d = P_ISSUE;
              end else begin
                state_d = P_DAT_H;
              end
            end
            P_DAT_H: begin
              dat_h_d = rx_data_s;
              state_d = P_DAT_L;
            end
            default: begin
              wen_d   = 1'b1;
              wadr_d  = adr_q;
              wdata_d = join16(dat_h_q, rx_data_s);
              state_d = P_ISSUE;
            end
          endcase
        end else if (tmo_q == TMO_M1) begin
          state_d = P_IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      P_ISSUE: begin
        lat_d = '0;
        if (is_rd_q) begin
          state_d = P_WAIT_RD;
        end else begin
`ifdef UART_IBUS_ACK_EN
          tx_start_s = 1'b1;
          tx_byte_s  = ACK_BYTE;
          state_d    = P_SEND_ACK;
`else
          state_d    = P_IDLE;
`endif
        end
      end
      P_WAIT_RD: begin
        if (lat_q == LAT_M1) begin
          reply_lo_d = ibus_rdata[7:0];
          tx_start_s = 1'b1;
          tx_byte_s  = ibus_rdata[15:8];
          state_d    = P_SEND_H;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      P_SEND_H: begin
        if (tx_done_s) begin
          tx_start_s = 1'b1;
          tx_byte_s  = reply_lo_q;
          state_d    = P_SEND_L;
        end else begin
          state_d = P_SEND_H;
        end
      end
      P_SEND_L, P_SEND_ACK: begin
        state_d = tx_done_s ? P_IDLE : state_q;
      end
      default: state_d = P_IDLE;
    endcase
  end

  // 8N1 shifter: a new start may load on the same cycle the previous stop bit ends.
  always_comb begin
    tx_d      = tx_q;
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bit_d  = tx_bit_q;
    if (tx_start_s) begin
      tx_busy_d = 1'b1;
      tx_d      = 1'b0;
      tx_sh_d   = {1'b1, tx_byte_s};
      tx_cnt_d  = '0;
      tx_bit_d  = 4'd0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_d      = 1'b1;
        end else begin
          tx_d     = tx_sh_q[0];
          tx_sh_d  = {1'b1, tx_sh_q[8:1]};
          tx_bit_d = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end else begin
      tx_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= P_IDLE;
      is_rd_q    <= 1'b0;
      adr_q      <= 16'h0000;
      dat_h_q    <= 8'h00;
      reply_lo_q <= 8'h00;
      tmo_q      <= '0;
      lat_q      <= '0;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      radr_q     <= 16'h0000;
      wadr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_sh_q    <= 9'h1FF;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      is_rd_q    <= is_rd_d;
      adr_q      <= adr_d;
      dat_h_q    <= dat_h_d;
      reply_lo_q <= reply_lo_d;
      tmo_q      <= tmo_d;
      lat_q      <= lat_d;
      ren_q      <= ren_d;
      wen_q      <= wen_d;
      radr_q     <= radr_d;
      wadr_q     <= wadr_d;
      wdata_q    <= wdata_d;
      ferr_q     <= ferr_d;
      busy_q     <= (state_d != P_IDLE) | tx_busy_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_sh_q    <= tx_sh_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  assign tx         = tx_q;
  assign ren        = ren_q;
  assign wen        = wen_q;
  assign ibus_radr  = radr_q;
  assign ibus_wadr  = wadr_q;
  assign ibus_wdata = wdata_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;

endmodule
